briham_code_detector: RTL and testbench
=======================================

Name: briham_code_detector

Overview:
- Registered 4-bit code detector.
- Samples four single-bit inputs A3..A0 as a code (A0 = LSB) and waits until the code has been stable for a configurable number of cycles.
- Once stable, drives LED high if the code is a member of a parameterised match set; default set is the 4-bit primes.
- Sits behind switch or pin inputs and drives a status LED directly.

Parameters:
- MATCH_SET, 16'h28AC, bit k = 1 means code k lights LED (default codes 2, 3, 5, 7, 11, 13).
- STABLE_CYCLES, 4, consecutive unchanged sampled cycles required before LED updates (legal range 1..255).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- A0  in  1  code bit 0 (LSB).
- A1  in  1  code bit 1.
- A2  in  1  code bit 2.
- A3  in  1  code bit 3 (MSB).
- LED  out  1  registered match indication.
- VALID  out  1  high while the current code has met the stability requirement.

Behaviour:
- Reset (async assert, sync release): code_q = 4'h0, cnt = 0, LED = 0, VALID = 0.
- Every clk edge:
  - code_q <= {A3,A2,A1,A0}.
  - If the new code differs from code_q: cnt <= 0 and VALID <= 0.
  - Else: cnt increments, saturating at STABLE_CYCLES-1.
- Decision: on any edge where the incoming code equals code_q and cnt == STABLE_CYCLES-1:
  - LED <= MATCH_SET[code_q].
  - VALID <= 1.
  - The same value is rewritten every cycle while stable.
- Latency: code first captured at edge k and held through edge k+STABLE_CYCLES gives LED/VALID updated at edge k+STABLE_CYCLES.
  - STABLE_CYCLES=1 gives a 2-edge end-to-end update.
- LED holds its last decided value while the code is changing (no glitch to 0); only VALID drops.
- A code change exactly on the decision edge aborts the update: cnt restarts, LED holds, VALID = 0.
- Counter width is ceil(log2(STABLE_CYCLES)) with a minimum of 1 bit; saturation means no wrap.
- Reset mid-stability discards progress. After release, the existing code needs a full STABLE_CYCLES to be accepted. The first post-reset capture compares against 4'h0, so input 0 held through reset counts as unchanged.
- LED is fully combinational-free at the output: driven directly from a flop.

Decomposition:
- Shared package briham_pkg holds:
  - CODE_W = 4.
  - DEFAULT_MATCH_SET = 16'h28AC.
  - A function is_match(set, code) returning set[code].
- One natural sub-module, stability_filter (code_q register plus saturating counter, outputs code_q and stable), parameterised by STABLE_CYCLES.
- The top instantiates it and registers LED/VALID.

Test Plan:
- Reset: assert rst with inputs 4'hD -> LED=0, VALID=0 immediately (async); release and hold 4'hD for 5 edges -> LED=1, VALID=1 at edge 4 after first capture.
- Exhaustive sweep: codes 0..15, each held 10 cycles, 10 ns clock -> LED=1 exactly for 2, 3, 5, 7, 11, 13 and 0 otherwise; VALID high from 4 edges after each change.
- Bounce: alternate 4'h7 / 4'h6 every cycle for 20 cycles after LED=0 -> LED stays 0, VALID stays 0; then hold 4'h7 -> LED=1 after 4 edges.
- Hold on change: LED=1 (code 3), switch to 4'h4 -> LED remains 1 for 3 edges with VALID=0, then LED=0 at the 4th edge.
- Parameter variant: STABLE_CYCLES=1, MATCH_SET=16'h8001 -> code 15 gives LED=1 two edges after the input is applied; code 14 gives LED=0.
- Mid-operation reset: hold 4'hB for 2 cycles and pulse rst between edges -> LED=0 at once, then 1 only after 4 further stable edges.

Source files
------------

// File: rtl/briham_code_detector_pkg.sv
// Shared definitions for the briham code detector: code width, default
// match set (the 4-bit primes) and the helpers used by the datapath.
package briham_pkg;

    localparam int CODE_W    = 4;
    localparam int NUM_CODES = 1 << CODE_W;

    typedef logic [CODE_W-1:0]    code_t;
    typedef logic [NUM_CODES-1:0] match_set_t;

    // Bit k set means code k lights the LED: codes 2, 3, 5, 7, 11, 13.
    localparam match_set_t DEFAULT_MATCH_SET = 16'h28AC;

    // Membership test of a code against a match set.
    function automatic logic is_match(input match_set_t set, input code_t code);
        return set[code];
    endfunction

    // Width of the stability counter: ceil(log2(n)), never below one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/briham_code_detector_if.sv
// Pin-level bundle of the code detector: four code bits in, LED and VALID out.
// The master side drives the code (switches / pins), the slave side is the
// detector itself.
interface briham_code_detector_if;

    logic A0;
    logic A1;
    logic A2;
    logic A3;
    logic LED;
    logic VALID;

    modport master (
        output A0,
        output A1,
        output A2,
        output A3,
        input  LED,
        input  VALID
    );

    modport slave (
        input  A0,
        input  A1,
        input  A2,
        input  A3,
        output LED,
        output VALID
    );

endinterface

// File: rtl/briham_code_detector_stability_filter.sv
// Stability filter: registers the incoming code every cycle and counts how
// many consecutive edges it has stayed unchanged. 'stable' flags the edge on
// which the code has been held long enough for a decision to be taken;
// 'changed' flags an edge on which the code differs from the registered one.
module stability_filter
    import briham_pkg::*;
#(
    parameter int STABLE_CYCLES = 4   // legal range 1..255
) (
    input  logic  clk,
    input  logic  rst,
    input  code_t code_in,
    output code_t code_q,
    output logic  stable,
    output logic  changed
);

    localparam int                CNT_W    = cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // Both flags look at the code about to be captured versus the one held,
    // so the decision and the abort happen on the same edge as the capture.
    assign changed = (code_in != code_q);
    assign stable  = !changed && (cnt == CNT_LAST);

    // Capture the code and run the saturating stability counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_q <= '0;
            cnt    <= '0;
        end else begin
            // NOTE: non-blocking assignments keep code_q and cnt updates based
            // on the pre-edge values, so compare-then-capture stays ordered.
            code_q <= code_in;
            if (changed) begin
                cnt <= '0;
            end else if (cnt != CNT_LAST) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/briham_code_detector.sv
// Registered 4-bit code detector. Once the code on A3..A0 has been stable for
// STABLE_CYCLES edges, LED shows whether it belongs to MATCH_SET and VALID
// goes high. While the code is changing LED keeps its last decided value and
// only VALID drops, so the status LED never glitches.
module briham_code_detector
    import briham_pkg::*;
#(
    parameter match_set_t MATCH_SET     = DEFAULT_MATCH_SET,
    parameter int         STABLE_CYCLES = 4   // legal range 1..255
) (
    input logic                  clk,
    input logic                  rst,
    briham_code_detector_if.slave bus
);

    code_t code_in;
    code_t code_q;
    logic  stable;
    logic  changed;
    logic  led_q;
    logic  valid_q;

    assign code_in = {bus.A3, bus.A2, bus.A1, bus.A0};

    stability_filter #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk     (clk),
        .rst     (rst),
        .code_in (code_in),
        .code_q  (code_q),
        .stable  (stable),
        .changed (changed)
    );

    // Decide LED on a stable edge; on a change only withdraw VALID.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_q   <= 1'b0;
            valid_q <= 1'b0;
        end else if (stable) begin
            led_q   <= is_match(MATCH_SET, code_q);
            valid_q <= 1'b1;
        end else if (changed) begin
            valid_q <= 1'b0;
        end
    end

    // Outputs come straight from flops, no logic after the registers.
    assign bus.LED   = led_q;
    assign bus.VALID = valid_q;

endmodule

// File: tb/tb_briham_code_detector.sv
// Directed bench for briham_code_detector: a default instance (primes,
// STABLE_CYCLES=4) and a variant (MATCH_SET=16'h8001, STABLE_CYCLES=1),
// both on a 10 ns clock with a shared reset.
module tb_briham_code_detector;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    briham_code_detector_if bus_main ();
    briham_code_detector_if bus_alt ();

    briham_code_detector dut_main (
        .clk (clk),
        .rst (rst),
        .bus (bus_main)
    );

    briham_code_detector #(
        .MATCH_SET     (16'h8001),
        .STABLE_CYCLES (1)
    ) dut_alt (
        .clk (clk),
        .rst (rst),
        .bus (bus_alt)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic observed, input logic expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    task automatic set_main(input logic [3:0] c);
        {bus_main.A3, bus_main.A2, bus_main.A1, bus_main.A0} = c;
    endtask

    task automatic set_alt(input logic [3:0] c);
        {bus_alt.A3, bus_alt.A2, bus_alt.A1, bus_alt.A0} = c;
    endtask

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hand-written list of 4-bit primes.
    function automatic logic prime_led(input int c);
        case (c)
            2, 3, 5, 7, 11, 13: return 1'b1;
            default:            return 1'b0;
        endcase
    endfunction

    // Apply a new code on the main instance and hold it for 'hold' edges.
    // Edge 1 captures it, edges 1..4 keep the previous LED with VALID low,
    // and from edge 5 on the decision is visible.
    task automatic hold_code(input logic [3:0] c, input logic prev_led, input int hold);
        logic exp_led;
        exp_led = prime_led(int'(c));
        set_main(c);
        for (int e = 1; e <= hold; e++) begin
            tick();
            if (e <= 4) begin
                check($sformatf("code%0d_edge%0d_valid", c, e), bus_main.VALID, 1'b0);
                check($sformatf("code%0d_edge%0d_led_hold", c, e), bus_main.LED, prev_led);
            end else begin
                check($sformatf("code%0d_edge%0d_valid", c, e), bus_main.VALID, 1'b1);
                check($sformatf("code%0d_edge%0d_led", c, e), bus_main.LED, exp_led);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic prev;

        // Power up with code D on the main side and 0 on the variant.
        set_main(4'hD);
        set_alt(4'h0);
        tick();
        tick();

        // Asynchronous reset between edges clears outputs at once.
        rst = 1'b1;
        #1;
        check("rst_async_led", bus_main.LED, 1'b0);
        check("rst_async_valid", bus_main.VALID, 1'b0);
        check("rst_async_alt_led", bus_alt.LED, 1'b0);
        check("rst_async_alt_valid", bus_alt.VALID, 1'b0);
        tick();
        check("rst_held_led", bus_main.LED, 1'b0);
        check("rst_held_valid", bus_main.VALID, 1'b0);
        rst = 1'b0;

        // Code D after release: captured at edge 1, decided at edge 5.
        hold_code(4'hD, 1'b0, 5);

        // Code 0 held through reset counts as unchanged: with one stable
        // cycle required the variant decides on the first edge (set bit 0).
        check("alt_zero_through_rst_led", bus_alt.LED, 1'b1);
        check("alt_zero_through_rst_valid", bus_alt.VALID, 1'b1);

        // Variant instance: two-edge end-to-end update.
        set_alt(4'hE);
        tick();
        check("alt_e_edge1_valid", bus_alt.VALID, 1'b0);
        check("alt_e_edge1_led_hold", bus_alt.LED, 1'b1);
        tick();
        check("alt_e_edge2_valid", bus_alt.VALID, 1'b1);
        check("alt_e_edge2_led", bus_alt.LED, 1'b0);
        set_alt(4'hF);
        tick();
        check("alt_f_edge1_valid", bus_alt.VALID, 1'b0);
        check("alt_f_edge1_led_hold", bus_alt.LED, 1'b0);
        tick();
        check("alt_f_edge2_valid", bus_alt.VALID, 1'b1);
        check("alt_f_edge2_led", bus_alt.LED, 1'b1);
        set_alt(4'hE);
        tick();
        check("alt_e2_edge1_valid", bus_alt.VALID, 1'b0);
        check("alt_e2_edge1_led_hold", bus_alt.LED, 1'b1);
        tick();
        check("alt_e2_edge2_valid", bus_alt.VALID, 1'b1);
        check("alt_e2_edge2_led", bus_alt.LED, 1'b0);
        check("main_steady_led", bus_main.LED, 1'b1);
        check("main_steady_valid", bus_main.VALID, 1'b1);

        // Sweep every code, each held 10 edges.
        prev = 1'b1;
        for (int c = 0; c < 16; c++) begin
            hold_code(4'(c), prev, 10);
            prev = prime_led(c);
        end

        // Bounce between 7 and 6 every cycle: nothing is ever accepted.
        for (int i = 0; i < 20; i++) begin
            set_main((i % 2 == 0) ? 4'h7 : 4'h6);
            tick();
            check($sformatf("bounce%0d_led", i), bus_main.LED, 1'b0);
            check($sformatf("bounce%0d_valid", i), bus_main.VALID, 1'b0);
        end
        hold_code(4'h7, 1'b0, 5);

        // LED holds through a change from 3 to 4 until 4 is decided.
        hold_code(4'h3, 1'b1, 6);
        hold_code(4'h4, 1'b1, 5);

        // Change exactly on the decision edge aborts the update.
        hold_code(4'h3, 1'b0, 5);
        set_main(4'h8);
        for (int e = 1; e <= 4; e++) begin
            tick();
            check($sformatf("abort_code8_edge%0d_valid", e), bus_main.VALID, 1'b0);
            check($sformatf("abort_code8_edge%0d_led", e), bus_main.LED, 1'b1);
        end
        set_main(4'hD);
        tick();
        check("abort_edge_valid", bus_main.VALID, 1'b0);
        check("abort_edge_led_hold", bus_main.LED, 1'b1);
        for (int e = 2; e <= 4; e++) begin
            tick();
            check($sformatf("after_abort_edge%0d_valid", e), bus_main.VALID, 1'b0);
        end
        tick();
        check("after_abort_decide_valid", bus_main.VALID, 1'b1);
        check("after_abort_decide_led", bus_main.LED, 1'b1);

        // Mid-operation reset discards progress on code B.
        set_main(4'hB);
        tick();
        tick();
        check("pre_midrst_led", bus_main.LED, 1'b1);
        check("pre_midrst_valid", bus_main.VALID, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_led", bus_main.LED, 1'b0);
        check("midrst_valid", bus_main.VALID, 1'b0);
        #1;
        rst = 1'b0;
        hold_code(4'hB, 1'b0, 5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
